multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, 16, maximum cycles a memory request may wait for mem_ack before the block faults; legal range 2..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 run  input  1  enables instruction sequencing; sampled in IDLE and at every instruction boundary.
REQ-005 opcode  input  11  instruction[31:21] from the instruction-field decoder; valid from the cycle after ir_write.
REQ-006 zero  input  1  ALU zero flag; valid in EXEC.
REQ-007 mem_ack  input  1  memory completion for the current request; single-cycle pulse.
REQ-008 mem_req, mem_read, mem_write, iord  output  1 each  memory request, direction, and address select (0 = PC, 1 = ALU result).
REQ-009 ir_write, pc_write, reg_write, alu_src, mem_to_reg  output  1 each  datapath enables and selects.
REQ-010 pc_src  output  2  00 = PC+4, 01 = branch target, 10 = jump target.
REQ-011 alu_op  output  2  00 = add (address), 01 = pass-B (CBZ), 10 = funct from opcode.
REQ-012 halted, err  output  1 each  HLT executed; fault, sticky until reset.
REQ-013 retired  output  16  count of completed instructions.

Function
REQ-014 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR; outputs are a combinational function of the state, the latched class, zero, and mem_ack; any output not listed for a state is 0.
REQ-015 IDLE SHALL go to FETCH when run=1 and otherwise stay in IDLE.
REQ-016 FETCH SHALL drive mem_req=1, mem_read=1, iord=0; in the mem_ack cycle it SHALL drive ir_write=1, pc_write=1, pc_src=00 and go to DECODE.
REQ-017 DECODE SHALL latch the opcode class: R (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000), LDUR 11111000010, STUR 11111000000, CBZ 10110100xxx, B 000101xxxxx, HLT 11010100010; any other opcode is ILLEGAL.
REQ-018 DECODE SHALL go to EXEC for R/LDUR/STUR/CBZ/B, to HALT for HLT, and to ERR for ILLEGAL.
REQ-019 EXEC for R SHALL drive alu_op=10, alu_src=0, then go to WB.
REQ-020 EXEC for LDUR/STUR SHALL drive alu_op=00, alu_src=1, then go to MEM.
REQ-021 EXEC for CBZ SHALL drive alu_op=01; when zero=1 it SHALL also drive pc_write=1, pc_src=01; it then ends the instruction.
REQ-022 EXEC for B SHALL drive pc_write=1, pc_src=10, then end the instruction.
REQ-023 MEM SHALL drive mem_req=1, iord=1, with mem_read=1 for LDUR and mem_write=1 for STUR; on mem_ack, LDUR goes to WB and STUR ends the instruction.
REQ-024 WB SHALL drive reg_write=1 and mem_to_reg=1 for LDUR, 0 for R, then end the instruction.
REQ-025 An instruction end SHALL increment retired by 1 (modulo 2^16 wrap) and go to FETCH if run=1, else to IDLE.
REQ-026 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle there without mem_ack.
REQ-027 When the wait counter reaches MEM_TIMEOUT-1 with mem_ack=0, the block SHALL go to ERR; mem_ack in that same cycle SHALL win and complete normally.
REQ-028 HALT SHALL drive halted=1 and ERR SHALL drive err=1; both states are absorbing, with all other outputs 0 and run ignored.
REQ-029 HLT and ILLEGAL SHALL NOT increment retired.
REQ-030 mem_ack received outside FETCH/MEM SHALL be ignored.

Reset
REQ-031 While rst_n=0 at a clock edge, the block SHALL enter IDLE, clear retired, the wait counter and the latched class, and drive all outputs to 0; this holds from any state, including mid-request and from HALT or ERR.
REQ-032 The first cycle after rst_n rises SHALL be IDLE regardless of run.

Verification
REQ-033 R-type: reset, run=1, opcode=10001011000, ack 1 cycle after each request -> FETCH,DECODE,EXEC,WB; reg_write=1 for one cycle; retired=1.
REQ-034 LDUR and STUR, ack delay 3 -> LDUR: mem_read with iord=1 in MEM, then WB with mem_to_reg=1. STUR: mem_write for 4 cycles, no reg_write; retired+1 for each.
REQ-035 CBZ with zero=1 and zero=0, then B -> pc_write with pc_src=01 only when zero=1; B gives pc_src=10; each instruction retires after EXEC.
REQ-036 Timeout, MEM_TIMEOUT=4: no ack -> ERR after 4 FETCH cycles, err=1 sticky; a repeat with ack on the 4th cycle -> DECODE, no err.
REQ-037 Boundaries: opcode 00000000000 -> ERR; HLT -> halted=1 with retired unchanged; rst_n=0 during MEM -> IDLE, all outputs 0; 65536 retirements -> retired wraps to 0; run=0 at WB -> IDLE.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle sequencer and its datapath/memory.
// The master side is the sequencer; the slave side is the datapath, instruction decoder and memory.
interface multicycle_ctrl_if;
    logic        run;
    logic [10:0] opcode;
    logic        zero;
    logic        mem_ack;

    logic        mem_req;
    logic        mem_read;
    logic        mem_write;
    logic        iord;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic        alu_src;
    logic        mem_to_reg;
    logic [1:0]  pc_src;
    logic [1:0]  alu_op;
    logic        halted;
    logic        err;
    logic [15:0] retired;

    modport master (
        input  run, opcode, zero, mem_ack,
        output mem_req, mem_read, mem_write, iord,
        output ir_write, pc_write, reg_write, alu_src, mem_to_reg,
        output pc_src, alu_op, halted, err, retired
    );

    modport slave (
        output run, opcode, zero, mem_ack,
        input  mem_req, mem_read, mem_write, iord,
        input  ir_write, pc_write, reg_write, alu_src, mem_to_reg,
        input  pc_src, alu_op, halted, err, retired
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle instruction sequencer for a small LEGv8-style datapath.
// Drives memory handshakes, datapath enables and a retired-instruction counter.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input logic               clk,
    input logic               rst_n,
    multicycle_ctrl_if.master bus
);
    localparam int unsigned WAIT_W = 8;
    localparam int unsigned RET_W  = 16;

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR
    } state_t;

    typedef enum logic [2:0] {
        CL_R, CL_LDUR, CL_STUR, CL_CBZ, CL_B, CL_HLT, CL_ILL
    } class_t;

    state_t            state;
    state_t            state_nx;
    class_t            cls;
    class_t            cls_nx;
    class_t            dec_cls;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nx;
    logic [RET_W-1:0]  retired_q;
    logic              retire_c;
    logic              wait_limit_c;

    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       alu_src;
    logic       mem_to_reg;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       halted;
    logic       err;

    // Opcode classification from instruction[31:21]
    always_comb begin
        dec_cls = CL_ILL;
        casez (bus.opcode)
            11'b10001011000,
            11'b11001011000,
            11'b10001010000,
            11'b10101010000: dec_cls = CL_R;
            11'b11111000010: dec_cls = CL_LDUR;
            11'b11111000000: dec_cls = CL_STUR;
            11'b10110100???: dec_cls = CL_CBZ;
            11'b000101?????: dec_cls = CL_B;
            11'b11010100010: dec_cls = CL_HLT;
            default:         dec_cls = CL_ILL;
        endcase
    end

    assign wait_limit_c = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

    // Next-state, class latch, wait counter and retire strobe
    always_comb begin
        state_nx = state;
        cls_nx   = cls;
        wait_nx  = wait_cnt;
        retire_c = 1'b0;

        case (state)
            IDLE: begin
                if (bus.run) begin
                    state_nx = FETCH;
                    wait_nx  = '0;
                end
            end
            FETCH: begin
                if (bus.mem_ack) begin
                    state_nx = DECODE;
                end else if (wait_limit_c) begin
                    state_nx = ERR;
                end else begin
                    wait_nx = wait_cnt + WAIT_W'(1);
                end
            end
            DECODE: begin
                cls_nx = dec_cls;
                case (dec_cls)
                    CL_HLT:  state_nx = HALT;
                    CL_ILL:  state_nx = ERR;
                    default: state_nx = EXEC;
                endcase
            end
            EXEC: begin
                case (cls)
                    CL_R: state_nx = WB;
                    CL_LDUR, CL_STUR: begin
                        state_nx = MEM;
                        wait_nx  = '0;
                    end
                    default: retire_c = 1'b1;
                endcase
            end
            MEM: begin
                if (bus.mem_ack) begin
                    if (cls == CL_LDUR) begin
                        state_nx = WB;
                    end else begin
                        retire_c = 1'b1;
                    end
                end else if (wait_limit_c) begin
                    state_nx = ERR;
                end else begin
                    wait_nx = wait_cnt + WAIT_W'(1);
                end
            end
            WB:      retire_c = 1'b1;
            HALT:    state_nx = HALT;
            ERR:     state_nx = ERR;
            default: state_nx = ERR;
        endcase

        // Instruction boundary: run is resampled here
        if (retire_c) begin
            state_nx = bus.run ? FETCH : IDLE;
            wait_nx  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cls       <= CL_R;
            wait_cnt  <= '0;
            retired_q <= '0;
        end else begin
            state     <= state_nx;
            cls       <= cls_nx;
            wait_cnt  <= wait_nx;
            retired_q <= retired_q + RET_W'(retire_c);
        end
    end

    // Datapath controls follow state, latched class, zero and mem_ack within the cycle
    always_comb begin
        mem_req    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        pc_src     = 2'b00;
        alu_op     = 2'b00;
        halted     = 1'b0;
        err        = 1'b0;

        case (state)
            FETCH: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                if (bus.mem_ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            EXEC: begin
                case (cls)
                    CL_R: alu_op = 2'b10;
                    CL_LDUR, CL_STUR: alu_src = 1'b1;
                    CL_CBZ: begin
                        alu_op = 2'b01;
                        if (bus.zero) begin
                            pc_write = 1'b1;
                            pc_src   = 2'b01;
                        end
                    end
                    CL_B: begin
                        pc_write = 1'b1;
                        pc_src   = 2'b10;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_read  = (cls == CL_LDUR);
                mem_write = (cls == CL_STUR);
            end
            WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls == CL_LDUR);
            end
            HALT:    halted = 1'b1;
            ERR:     err    = 1'b1;
            default: ;
        endcase
    end

    assign bus.mem_req    = mem_req;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.iord       = iord;
    assign bus.ir_write   = ir_write;
    assign bus.pc_write   = pc_write;
    assign bus.reg_write  = reg_write;
    assign bus.alu_src    = alu_src;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.pc_src     = pc_src;
    assign bus.alu_op     = alu_op;
    assign bus.halted     = halted;
    assign bus.err        = err;
    assign bus.retired    = retired_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes per-cycle expected controls,
// a negedge monitor pops and compares.
module tb_multicycle_ctrl;
    localparam int unsigned TO = 4;

    // Control vector order: mem_req mem_read mem_write iord ir_write pc_write
    // reg_write alu_src mem_to_reg pc_src[1:0] alu_op[1:0] halted err
    localparam logic [14:0] O_NONE = 15'b000000000_00_00_00;
    localparam logic [14:0] O_FW   = 15'b110000000_00_00_00;
    localparam logic [14:0] O_FA   = 15'b110011000_00_00_00;
    localparam logic [14:0] O_EXR  = 15'b000000000_00_10_00;
    localparam logic [14:0] O_EXLS = 15'b000000010_00_00_00;
    localparam logic [14:0] O_CBZN = 15'b000000000_00_01_00;
    localparam logic [14:0] O_CBZT = 15'b000001000_01_01_00;
    localparam logic [14:0] O_B    = 15'b000001000_10_00_00;
    localparam logic [14:0] O_MLD  = 15'b110100000_00_00_00;
    localparam logic [14:0] O_MST  = 15'b101100000_00_00_00;
    localparam logic [14:0] O_WBR  = 15'b000000100_00_00_00;
    localparam logic [14:0] O_WBLD = 15'b000000101_00_00_00;
    localparam logic [14:0] O_HALT = 15'b000000000_00_00_10;
    localparam logic [14:0] O_ERR  = 15'b000000000_00_00_01;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_B    = 11'b00010110011;
    localparam logic [10:0] OP_HLT  = 11'b11010100010;
    localparam logic [10:0] OP_ILL  = 11'b00000000000;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [30:0] exp_q[$];
    string       tag_q[$];
    int          n_vec = 0;
    int          n_bad = 0;

    // Monitor: one expected vector per cycle, sampled mid-cycle
    always @(negedge clk) begin
        logic [30:0] obs;
        logic [30:0] e;
        string       t;
        if (exp_q.size() > 0) begin
            obs = {bus.mem_req, bus.mem_read, bus.mem_write, bus.iord, bus.ir_write,
                   bus.pc_write, bus.reg_write, bus.alu_src, bus.mem_to_reg,
                   bus.pc_src, bus.alu_op, bus.halted, bus.err, bus.retired};
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL %s: got ctl=%b retired=%h, expected ctl=%b retired=%h",
                         t, obs[30:16], obs[15:0], e[30:16], e[15:0]);
            end
        end
    end

    task automatic step(input string t, input logic ack, input logic [14:0] c,
                        input logic [15:0] ret);
        bus.mem_ack = ack;
        exp_q.push_back({c, ret});
        tag_q.push_back(t);
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input int unsigned n);
        bus.mem_ack = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int unsigned waits, input logic [15:0] ret);
        for (int i = 0; i < int'(waits); i++) step("fetch_wait", 1'b0, O_FW, ret);
        step("fetch_ack", 1'b1, O_FA, ret);
    endtask

    task automatic mem(input string t, input int unsigned waits, input logic [14:0] c,
                       input logic [15:0] ret);
        for (int i = 0; i < int'(waits); i++) step(t, 1'b0, c, ret);
        step(t, 1'b1, c, ret);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.run     = 1'b1;
        bus.opcode  = OP_ILL;
        bus.zero    = 1'b0;
        bus.mem_ack = 1'b0;
        hold(2);
        step("reset_state", 1'b0, O_NONE, 16'd0);
        rst_n = 1'b1;
        step("idle_after_reset", 1'b0, O_NONE, 16'd0);

        // R-type, ack one cycle after request; stray zero is harmless
        fetch(1, 16'd0);
        bus.opcode = OP_ADD;
        bus.zero   = 1'b1;
        step("r_decode", 1'b0, O_NONE, 16'd0);
        step("r_exec",   1'b0, O_EXR,  16'd0);
        step("r_wb",     1'b0, O_WBR,  16'd0);

        // LDUR, memory ack on the 4th cycle (wait count at limit)
        fetch(0, 16'd1);
        bus.opcode = OP_LDUR;
        step("ld_decode", 1'b0, O_NONE, 16'd1);
        step("ld_exec",   1'b0, O_EXLS, 16'd1);
        mem("ld_mem", 3, O_MLD, 16'd1);
        step("ld_wb",     1'b0, O_WBLD, 16'd1);

        // STUR, four cycles of mem_write and no write-back
        fetch(0, 16'd2);
        bus.opcode = OP_STUR;
        step("st_decode", 1'b0, O_NONE, 16'd2);
        step("st_exec",   1'b0, O_EXLS, 16'd2);
        mem("st_mem", 3, O_MST, 16'd2);

        // CBZ taken, then not taken
        fetch(0, 16'd3);
        bus.opcode = OP_CBZ;
        step("cbz_t_decode", 1'b0, O_NONE, 16'd3);
        step("cbz_t_exec",   1'b0, O_CBZT, 16'd3);
        fetch(0, 16'd4);
        bus.zero = 1'b0;
        step("cbz_n_decode", 1'b0, O_NONE, 16'd4);
        step("cbz_n_exec",   1'b0, O_CBZN, 16'd4);

        // B with stray acks outside memory states
        fetch(0, 16'd5);
        bus.opcode = OP_B;
        step("b_decode", 1'b1, O_NONE, 16'd5);
        step("b_exec",   1'b1, O_B,    16'd5);

        // SUB with run dropped at write-back
        fetch(0, 16'd6);
        bus.opcode = OP_SUB;
        step("sub_decode", 1'b0, O_NONE, 16'd6);
        step("sub_exec",   1'b0, O_EXR,  16'd6);
        bus.run = 1'b0;
        step("sub_wb",     1'b0, O_WBR,  16'd6);
        step("idle_run0",  1'b0, O_NONE, 16'd7);
        step("idle_ack",   1'b1, O_NONE, 16'd7);

        // HLT fetched with ack on the last legal cycle; retired unchanged
        bus.run = 1'b1;
        step("idle_go", 1'b0, O_NONE, 16'd7);
        fetch(3, 16'd7);
        bus.opcode = OP_HLT;
        step("hlt_decode", 1'b0, O_NONE, 16'd7);
        bus.run = 1'b0;
        step("halt",       1'b0, O_HALT, 16'd7);
        bus.run = 1'b1;
        step("halt_run",   1'b1, O_HALT, 16'd7);
        step("halt_stay",  1'b0, O_HALT, 16'd7);

        // Reset out of HALT, then fetch timeout
        rst_n = 1'b0;
        hold(1);
        step("reset_from_halt", 1'b0, O_NONE, 16'd0);
        rst_n = 1'b1;
        step("idle2", 1'b0, O_NONE, 16'd0);
        for (int i = 0; i < 4; i++) step("fetch_timeout", 1'b0, O_FW, 16'd0);
        step("err", 1'b0, O_ERR, 16'd0);
        bus.run = 1'b0;
        step("err_sticky", 1'b1, O_ERR, 16'd0);
        bus.run = 1'b1;
        step("err_sticky2", 1'b0, O_ERR, 16'd0);

        // Reset, one B, then an illegal opcode
        rst_n = 1'b0;
        hold(1);
        step("reset_from_err", 1'b0, O_NONE, 16'd0);
        rst_n = 1'b1;
        step("idle3", 1'b0, O_NONE, 16'd0);
        fetch(0, 16'd0);
        bus.opcode = OP_B;
        step("b2_decode", 1'b0, O_NONE, 16'd0);
        step("b2_exec",   1'b0, O_B,    16'd0);
        fetch(0, 16'd1);
        bus.opcode = OP_ILL;
        step("ill_decode", 1'b0, O_NONE, 16'd1);
        step("ill_err",    1'b0, O_ERR,  16'd1);
        step("ill_sticky", 1'b0, O_ERR,  16'd1);

        // Reset asserted in the middle of a load's memory phase
        rst_n = 1'b0;
        hold(1);
        step("reset_from_ill", 1'b0, O_NONE, 16'd0);
        rst_n = 1'b1;
        step("idle4", 1'b0, O_NONE, 16'd0);
        fetch(0, 16'd0);
        bus.opcode = OP_LDUR;
        step("ld2_decode", 1'b0, O_NONE, 16'd0);
        step("ld2_exec",   1'b0, O_EXLS, 16'd0);
        step("ld2_mem",    1'b0, O_MLD,  16'd0);
        step("ld2_mem2",   1'b0, O_MLD,  16'd0);
        rst_n = 1'b0;
        hold(1);
        step("reset_mid_mem",     1'b0, O_NONE, 16'd0);
        step("reset_mid_mem_ack", 1'b1, O_NONE, 16'd0);
        bus.run = 1'b0;
        rst_n   = 1'b1;
        step("idle5", 1'b0, O_NONE, 16'd0);

        // Retired counter wrap, starting two below the top
        force dut.retired_q = 16'hFFFE;
        step("preload", 1'b0, O_NONE, 16'hFFFE);
        release dut.retired_q;
        bus.run = 1'b1;
        step("idle_go2", 1'b0, O_NONE, 16'hFFFE);
        fetch(0, 16'hFFFE);
        bus.opcode = OP_B;
        step("w1_decode", 1'b0, O_NONE, 16'hFFFE);
        step("w1_exec",   1'b0, O_B,    16'hFFFE);
        fetch(0, 16'hFFFF);
        step("w2_decode", 1'b0, O_NONE, 16'hFFFF);
        bus.run = 1'b0;
        step("w2_exec",   1'b0, O_B,    16'hFFFF);
        step("wrap",      1'b0, O_NONE, 16'h0000);

        hold(2);
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d vectors left, required 0", exp_q.size());
            n_bad++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
